// File: rtl/io_responder_if.sv
// IO-side request/ready bus between the data-address splitter and io_responder.
// io_data is bidirectional and is therefore carried as a separate inout port of the responder.
interface io_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] io_addr;
  logic                  io_read;
  logic                  io_write;
  logic                  io_ready;

  modport master (
    output io_addr,
    output io_read,
    output io_write,
    input  io_ready
  );

  modport slave (
    input  io_addr,
    input  io_read,
    input  io_write,
    output io_ready
  );
endinterface

// File: rtl/io_responder.sv
// IO responder: GPIO, free-running timer with compare, control/status, wait-stated ready handshake.
// Define TIMER_IRQ_EN to drive irq from STATUS.MATCH & CTRL.IRQ_MASK; otherwise irq is tied low.
module io_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int GPIO_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_responder_if.slave         bus,
  inout  wire  [DATA_WIDTH-1:0] io_data,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_DONE
  } state_e;

  localparam logic [2:0] IDX_GPIO_OUT = 3'd0;
  localparam logic [2:0] IDX_GPIO_IN  = 3'd1;
  localparam logic [2:0] IDX_CNT      = 3'd2;
  localparam logic [2:0] IDX_CMP      = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;
  localparam logic [2:0] IDX_STATUS   = 3'd5;

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [2:0]              idx_q, idx_d;
  logic                    op_wr_q, op_wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [GPIO_WIDTH-1:0]   gpio_out_q, gpio_out_d;
  logic [GPIO_WIDTH-1:0]   sync1_q, sync1_d;
  logic [GPIO_WIDTH-1:0]   sync2_q, sync2_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   cmp_q, cmp_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic                    match_q, match_d;

  logic                    req;
  logic                    commit;
  logic                    hit;
  logic                    drive;
  logic [2:0]              rd_idx;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    unused_addr_bits;

  assign req    = bus.io_read | bus.io_write;
  assign commit = (state_q == S_ACK) && op_wr_q;
  assign hit    = (cnt_q == cmp_q);
  assign drive  = ((state_q == S_ACK) || (state_q == S_DONE)) && !op_wr_q;

  assign bus.io_ready = (state_q == S_ACK) || (state_q == S_DONE);
  assign io_data      = drive ? rdata_q : {DATA_WIDTH{1'bz}};
  assign gpio_out     = gpio_out_q;

  // Only the word index is decoded; the splitter has already rebased the offset.
  assign unused_addr_bits = ^bus.io_addr[ADDR_WIDTH-1:3];

  // In IDLE the index is not latched yet, so a zero-wait read samples straight from the bus.
  assign rd_idx = (state_q == S_IDLE) ? bus.io_addr[2:0] : idx_q;

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      IDX_GPIO_OUT: rd_val[GPIO_WIDTH-1:0] = gpio_out_q;
      IDX_GPIO_IN:  rd_val[GPIO_WIDTH-1:0] = sync2_q;
      IDX_CNT:      rd_val = cnt_q;
      IDX_CMP:      rd_val = cmp_q;
      IDX_CTRL:     rd_val[2:0] = ctrl_q;
      IDX_STATUS:   rd_val[0] = match_q;
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    op_wr_d = op_wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = bus.io_addr[2:0];
          op_wr_d = bus.io_write;
          wdata_d = io_data;
          wcnt_d  = '0;
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            rdata_d = rd_val;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (wcnt_q == WS_LAST) begin
          state_d = S_ACK;
          rdata_d = rd_val;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_ACK:   state_d = S_DONE;
      S_DONE:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register file and timer; a software write to CNT overrides the increment/reload.
  always_comb begin
    gpio_out_d = gpio_out_q;
    cnt_d      = cnt_q;
    cmp_d      = cmp_q;
    ctrl_d     = ctrl_q;
    match_d    = match_q;
    sync1_d    = gpio_in;
    sync2_d    = sync1_q;
    if (ctrl_q[0]) begin
      cnt_d = (hit && ctrl_q[1]) ? '0 : cnt_q + DATA_WIDTH'(1);
    end
    if (commit) begin
      case (idx_q)
        IDX_GPIO_OUT: gpio_out_d = wdata_q[GPIO_WIDTH-1:0];
        IDX_CNT:      cnt_d      = wdata_q;
        IDX_CMP:      cmp_d      = wdata_q;
        IDX_CTRL:     ctrl_d     = wdata_q[2:0];
        IDX_STATUS:   if (wdata_q[0]) match_d = 1'b0;
        default:      ;
      endcase
    end
    // A match in the same cycle as the W1C keeps the flag set.
    if (ctrl_q[0] && hit) match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      idx_q      <= '0;
      op_wr_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      cmp_q      <= '0;
      ctrl_q     <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      idx_q      <= idx_d;
      op_wr_q    <= op_wr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = match_q & ctrl_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: directed scenarios plus randomized register traffic,
// with a closed-form timer/match model kept at cycle-number granularity.
module tb_io_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 8;
  localparam int WS = 1;
  localparam longint TWO32 = 64'h1_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [GW-1:0] gpio_in = '0;
  wire  [GW-1:0] gpio_out;
  wire           irq;
  wire  [DW-1:0] io_data;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_wdata = '0;

  assign io_data = tb_drv ? tb_wdata : {DW{1'bz}};

  io_responder_if #(.ADDR_WIDTH(AW)) bus ();

  io_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .GPIO_WIDTH (GW),
    .WAIT_STATES(WS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .io_data (io_data),
    .gpio_out(gpio_out),
    .gpio_in (gpio_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  // Reference model: timer is a segment (value tbase at cycle cbase) under fixed settings.
  logic [GW-1:0] gpio_m;
  longint tbase, cbase, cmp_m, last_event, last_clear;
  bit en_m, ar_m, mask_m;

  function automatic longint cnt_at(input longint c);
    longint k, f;
    if (!en_m) return tbase;
    k = c - cbase;
    f = (cmp_m - tbase) & (TWO32 - 1);
    if (ar_m && k > f) return (k - f - 1) % (cmp_m + 1);
    return (tbase + k) & (TWO32 - 1);
  endfunction

  function automatic longint last_event_in(input longint a, input longint b);
    longint e0, p, e;
    if (!en_m) return -1;
    e0 = cbase + ((cmp_m - tbase) & (TWO32 - 1));
    if (b < e0 || b < a) return -1;
    p = ar_m ? cmp_m + 1 : TWO32;
    e = e0 + ((b - e0) / p) * p;
    return (e >= a) ? e : -1;
  endfunction

  function automatic bit match_at(input longint c);
    longint le, t;
    le = last_event;
    t  = last_event_in(cbase, c - 1);
    if (t > le) le = t;
    return (le >= 0) && (le >= last_clear);
  endfunction

  function automatic void rebase(input longint r);
    longint t;
    t = last_event_in(cbase, r - 1);
    if (t > last_event) last_event = t;
    tbase = cnt_at(r);
    cbase = r;
  endfunction

  function automatic void model_reset();
    gpio_m = '0; tbase = 0; cbase = cyc; cmp_m = 0;
    en_m = 0; ar_m = 0; mask_m = 0;
    last_event = -1; last_clear = -1;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [2:0] idx, input longint c);
    logic [DW-1:0] v;
    v = '0;
    case (idx)
      3'd0: v[GW-1:0] = gpio_m;
      3'd1: v[GW-1:0] = gpio_in;
      3'd2: v = DW'(cnt_at(c));
      3'd3: v = DW'(cmp_m);
      3'd4: v[2:0] = {mask_m, ar_m, en_m};
      3'd5: v[0] = match_at(c);
      default: v = '0;
    endcase
    return v;
  endfunction

  // K is the cycle in which the write is acknowledged; its effect is visible from K+1.
  function automatic void model_write(input logic [2:0] idx, input logic [DW-1:0] wd, input longint k);
    case (idx)
      3'd0: gpio_m = wd[GW-1:0];
      3'd2: begin rebase(k + 1); tbase = longint'(wd); end
      3'd3: begin rebase(k + 1); cmp_m = longint'(wd); end
      3'd4: begin rebase(k + 1); en_m = wd[0]; ar_m = wd[1]; mask_m = wd[2]; end
      3'd5: if (wd[0]) last_clear = k;
      default: ;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_released(input string nm);
    nvec++;
    if (!((io_data === {DW{1'bz}}) || (io_data === '0))) begin
      nmis++;
      $display("FAIL %s: io_data=0x%0h expected released (cycle %0d)", nm, io_data, cyc);
    end
  endtask

  typedef struct {
    bit            is_read;
    logic [DW-1:0] data;
    int            rcyc;
  } exp_t;

  exp_t sbq[$];

  // Monitor: pops one expectation per ready assertion and checks latency and read data.
  initial begin
    exp_t cur;
    bit   in_resp;
    in_resp = 0;
    cur = '{is_read: 1'b0, data: '0, rcyc: 0};
    forever begin
      @(negedge clk);
      if (bus.io_ready === 1'b1) begin
        if (!in_resp) begin
          in_resp = 1;
          if (sbq.size() == 0) begin
            nvec++; nmis++;
            $display("FAIL unexpected_ready: got io_ready=1 expected 0 (cycle %0d)", cyc);
            cur = '{is_read: 1'b0, data: '0, rcyc: 0};
          end else begin
            cur = sbq.pop_front();
            check("ready_latency", 64'(cyc), 64'(cur.rcyc));
            if (cur.is_read) check("read_data_ack", io_data, cur.data);
          end
        end else if (cur.is_read) begin
          check("read_data_done", io_data, cur.data);
        end
      end else if (in_resp) begin
        in_resp = 0;
        if (cur.is_read) check_released("read_release");
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [2:0] idx,
                        input logic [DW-1:0] wd, input bit align);
    exp_t e;
    int   n;
    bit   got;
    @(posedge clk); #1;
    n = cyc;
    if (align) begin
      for (int i = 0; i < 16 && cnt_at(n + WS + 1) != cmp_m; i++) begin
        @(posedge clk); #1;
        n = cyc;
      end
    end
    bus.io_addr = $urandom();
    bus.io_addr[2:0] = idx;
    bus.io_read = rd;
    bus.io_write = wr;
    tb_wdata = wd;
    tb_drv = wr;
    e.is_read = rd && !wr;
    e.rcyc = n + WS + 1;
    e.data = e.is_read ? model_read(idx, n + WS) : '0;
    if (wr) model_write(idx, wd, n + WS + 1);
    sbq.push_back(e);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.io_ready === 1'b1);
    end
    if (!got) begin
      nvec++; nmis++;
      $display("FAIL ready_timeout: got no io_ready expected at cycle %0d", e.rcyc);
    end
    @(posedge clk); #1;
    bus.io_read = 1'b0;
    bus.io_write = 1'b0;
    tb_drv = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (bus.io_ready === 1'b0);
    end
    if (!got) begin
      nvec++; nmis++;
      $display("FAIL ready_release_timeout: got io_ready=1 expected 0 (cycle %0d)", cyc);
    end
  endtask

  task automatic abort_write(input logic [2:0] idx, input logic [DW-1:0] wd);
    @(posedge clk); #1;
    bus.io_addr = {29'd0, idx};
    bus.io_write = 1'b1;
    tb_wdata = wd;
    tb_drv = 1'b1;
    @(posedge clk); #1;
    bus.io_write = 1'b0;
    tb_drv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_ready", bus.io_ready, 0);
    end
  endtask

  task automatic irq_window(input int n);
    repeat (n) begin
      @(negedge clk);
`ifdef TIMER_IRQ_EN
      check("irq", irq, 64'(mask_m && match_at(cyc - 1)));
`else
      check("irq", irq, 0);
`endif
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    bit   got;
    bus.io_addr = '0;
    bus.io_read = 1'b0;
    bus.io_write = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", bus.io_ready, 0);
    check("reset_gpio_out", gpio_out, 0);
    check("reset_irq", irq, 0);
    check_released("reset_data");
    rst_n = 1'b1;
    model_reset();

    // GPIO_OUT write
    access(0, 1, 3'd0, 32'h0000_00A5, 0);
    check("gpio_out_a5", gpio_out, 8'hA5);

    // GPIO_IN read through the synchronizer
    gpio_in = 8'h3C;
    repeat (3) @(posedge clk);
    access(1, 0, 3'd1, '0, 0);

    // Auto-reload timer, period CMP+1
    access(0, 1, 3'd3, 32'd5, 0);
    access(0, 1, 3'd4, 32'h3, 0);
    repeat (4) access(1, 0, 3'd2, '0, 0);
    access(1, 0, 3'd5, '0, 0);
    access(1, 0, 3'd5, '0, 0);
    irq_window(12);
    access(0, 1, 3'd4, 32'h0, 0);
    access(0, 1, 3'd5, 32'h1, 0);
    access(1, 0, 3'd5, '0, 0);
    access(1, 0, 3'd2, '0, 0);

    // Request withdrawn during wait states
    abort_write(3'd0, 32'h5A);
    access(1, 0, 3'd0, '0, 0);
    check("gpio_out_after_abort", gpio_out, 8'hA5);

    // Counter wrap
    access(0, 1, 3'd3, 32'h10, 0);
    access(0, 1, 3'd4, 32'h1, 0);
    access(0, 1, 3'd2, 32'hFFFF_FFFF, 0);
    access(1, 0, 3'd2, '0, 0);
    access(1, 0, 3'd2, '0, 0);

    // W1C landing on a match cycle, with interrupt mask set
    access(0, 1, 3'd2, 32'h0, 0);
    access(0, 1, 3'd3, 32'd5, 0);
    access(0, 1, 3'd4, 32'h7, 0);
    irq_window(10);
    access(0, 1, 3'd5, 32'h1, 1);
    access(1, 0, 3'd5, '0, 0);
    irq_window(10);

    // Randomized register traffic
    repeat (80) begin
      logic [2:0]    idx;
      logic [DW-1:0] wd;
      int            mode;
      idx = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 3);
      case (idx)
        3'd2: wd = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 15));
        3'd3: wd = 32'($urandom_range(0, 12));
        default: wd = $urandom();
      endcase
      if ($urandom_range(0, 9) == 0) begin
        gpio_in = 8'($urandom());
        repeat (3) @(posedge clk);
      end
      access(mode < 2, mode >= 2, idx, wd, 0);
    end

    // Asynchronous reset while a read is being acknowledged
    gpio_in = 8'h81;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    n = cyc;
    bus.io_addr = 32'h1;
    bus.io_read = 1'b1;
    e.is_read = 1;
    e.rcyc = n + WS + 1;
    e.data = model_read(3'd1, n + WS);
    sbq.push_back(e);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.io_ready === 1'b1);
    end
    if (!got) begin
      nvec++; nmis++;
      $display("FAIL rst_ack_timeout: got no io_ready expected at cycle %0d", e.rcyc);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ack_ready", bus.io_ready, 0);
    check_released("rst_mid_ack_data");
    bus.io_read = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpio_out", gpio_out, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    access(1, 0, 3'd4, '0, 0);
    access(1, 0, 3'd1, '0, 0);
    access(1, 0, 3'd6, '0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
